// File: rtl/img_pkt_pkg.sv
// rtl/img_pkt_pkg.sv - shared constants and FSM encoding for the image packetizer/depacketizer pair
package img_pkt_pkg;

    localparam logic [31:0] FRAME_HEAD = 32'hF05A_A50F;
    localparam int          H_PIXEL    = 640;
    localparam int          V_PIXEL    = 480;
    localparam int          LINE_BYTES = 2 * H_PIXEL;
    localparam int          HEAD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_DATA,
        ST_DROP
    } depkt_state_t;

    function automatic logic [15:0] line_bytes(input int h_pixel);
        return 16'(2 * h_pixel);
    endfunction

endpackage

// File: rtl/pix_word_ser.sv
// rtl/pix_word_ser.sv - splits a 32-bit payload word into two RGB565 pixels, high half first
module pix_word_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        first,
    input  logic [31:0] word,
    output logic        busy,
    output logic        pix_de,
    output logic [15:0] pix_data,
    output logic [10:0] pix_x,
    output logic        ovf
);

    logic [15:0] low_data;
    logic [10:0] x_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            pix_de   <= 1'b0;
            pix_data <= '0;
            pix_x    <= '0;
            ovf      <= 1'b0;
            low_data <= '0;
            x_next   <= '0;
        end else if (load && !busy) begin
            pix_de   <= 1'b1;
            pix_data <= word[31:16];
            low_data <= word[15:0];
            busy     <= 1'b1;
            pix_x    <= first ? 11'd0 : x_next;
            x_next   <= first ? 11'd1 : x_next + 11'd1;
        end else if (busy) begin
            // A word arriving while the low half is still due is lost; only the flag remembers it.
            pix_de   <= 1'b1;
            pix_data <= low_data;
            pix_x    <= x_next;
            x_next   <= x_next + 11'd1;
            busy     <= 1'b0;
            if (load) begin
                ovf <= 1'b1;
            end
        end else begin
            pix_de <= 1'b0;
        end
    end

endmodule

// File: rtl/img_data_depkt.sv
// rtl/img_data_depkt.sv - reassembles RGB565 raster frames from received UDP payload words
module img_data_depkt #(
    parameter int          H_PIXEL    = img_pkt_pkg::H_PIXEL,
    parameter int          V_PIXEL    = img_pkt_pkg::V_PIXEL,
    parameter logic [31:0] FRAME_HEAD = img_pkt_pkg::FRAME_HEAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rec_en,
    input  logic [31:0] rec_data,
    input  logic        rec_pkt_done,
    input  logic [15:0] rec_byte_num,
    output logic        frame_start,
    output logic        frame_done,
    output logic        pix_de,
    output logic [15:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pkt_err,
    output logic        ovf_err
);

    import img_pkt_pkg::*;

    localparam logic [10:0] WPL      = 11'(H_PIXEL / 2);
    localparam logic [10:0] LINES    = 11'(V_PIXEL);
    localparam logic [15:0] LEN_LINE = line_bytes(H_PIXEL);
    localparam logic [15:0] LEN_HEAD = LEN_LINE + 16'(HEAD_BYTES);

    depkt_state_t state, eff;
    logic         in_frame, had_head, fd_pend, ser_busy;
    logic [10:0]  line, wcnt;

    logic         is_head, head_take, data_first, drop_first, word_in, ser_load, ser_first;
    logic         in_pkt, len_ok, done_ok, done_bad, last_line, fd_fire, head_base, in_frame_base;
    logic [10:0]  wcnt_base, wcnt_now, line_base, line_inc;

    // The first word of a packet is judged in the same cycle it arrives, so FIRST is never held.
    always_comb begin
        eff           = (state == ST_IDLE && rec_en) ? ST_FIRST : state;
        is_head       = (rec_data == FRAME_HEAD);
        head_take     = (eff == ST_FIRST) && is_head;
        data_first    = (eff == ST_FIRST) && !is_head && in_frame && (line < LINES);
        drop_first    = (eff == ST_FIRST) && !head_take && !data_first;
        head_base     = (eff == ST_FIRST) ? is_head : had_head;
        wcnt_base     = (eff == ST_FIRST) ? 11'd0 : wcnt;
        line_base     = head_take ? 11'd0 : line;
        in_frame_base = head_take ? 1'b1 : in_frame;
        word_in       = ((eff == ST_DATA) && rec_en) || data_first;
        ser_load      = word_in && (wcnt_base < WPL);
        ser_first     = (wcnt_base == 11'd0);
        wcnt_now      = (word_in && wcnt_base <= WPL) ? wcnt_base + 11'd1 : wcnt_base;
        line_inc      = line_base + 11'd1;
        in_pkt        = (eff == ST_DATA) || head_take || data_first;
        len_ok        = rec_byte_num == (head_base ? LEN_HEAD : LEN_LINE);
        done_ok       = rec_pkt_done && in_pkt && (wcnt_now == WPL) && len_ok;
        done_bad      = rec_pkt_done && ((in_pkt && !done_ok) || (eff == ST_DROP) || drop_first);
        last_line     = done_ok && (line_inc == LINES);
        fd_fire       = (fd_pend || last_line) && !ser_busy && !ser_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_frame    <= 1'b0;
            had_head    <= 1'b0;
            fd_pend     <= 1'b0;
            line        <= '0;
            wcnt        <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            pkt_err     <= 1'b0;
        end else begin
            frame_start <= head_take;
            frame_done  <= fd_fire;
            pkt_err     <= done_bad;
            fd_pend     <= (fd_pend || last_line) && !fd_fire;
            wcnt        <= wcnt_now;
            line        <= done_ok ? line_inc : line_base;
            in_frame    <= last_line ? 1'b0 : in_frame_base;
            if (eff == ST_FIRST) begin
                had_head <= is_head;
            end
            if (ser_load) begin
                pix_y <= line_base;
            end
            case (eff)
                ST_FIRST: begin
                    if (rec_pkt_done)    state <= ST_IDLE;
                    else if (drop_first) state <= ST_DROP;
                    else                 state <= ST_DATA;
                end
                ST_DATA, ST_DROP: begin
                    if (rec_pkt_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pix_word_ser u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .first    (ser_first),
        .word     (rec_data),
        .busy     (ser_busy),
        .pix_de   (pix_de),
        .pix_data (pix_data),
        .pix_x    (pix_x),
        .ovf      (ovf_err)
    );

endmodule
